// File: rtl/uart_tx_buffered_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered_pkg
// Shared constants for the buffered UART transmitter.
//  - Baud divisors for a 50 MHz system clock (clocks per bit). The top level
//    takes one of these as its BAUD_DIV parameter.
//  - Frame layout constants used by the serializer.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_tx_buffered_pkg;

   // Clocks per bit at 50 MHz, rounded to the nearest integer
   localparam int unsigned B9600   = 32'd5208;
   localparam int unsigned B19200  = 32'd2604;
   localparam int unsigned B115200 = 32'd434;

   // Index of the last data bit in an 8N1 frame
   localparam logic [2:0] LAST_DATA_BIT = 3'd7;

endpackage : uart_tx_buffered_pkg

// File: rtl/uart_tx_buffered_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered storage and a registered occupancy count.
// Ports:
//  clk    in   1     system clock
//  rstn   in   1     synchronous active-low reset (empties the FIFO)
//  push   in   1     write request; ignored while full
//  pop    in   1     read request; ignored while empty
//  din    in   W     write data
//  dout   out  W     head of the FIFO (valid while !empty)
//  full   out  1     level == 2**AW
//  empty  out  1     level == 0
//  level  out  AW+1  number of stored entries
// Full is evaluated from the registered level, so a push on the same edge as a
// pop from a full FIFO is still refused.
// -----------------------------------------------------------------------------
module sync_fifo
   import uart_tx_buffered_pkg::*;
#(
   parameter int unsigned W  = 8,
   parameter int unsigned AW = 4
)(
   input  logic          clk,
   input  logic          rstn,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);

   localparam int unsigned LW    = AW + 1;
   localparam int unsigned DEPTH = 32'd1 << AW;
   localparam logic [AW:0] LEVEL_FULL = LW'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q,  level_d;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign full      = (level_q == LEVEL_FULL);
   assign empty     = (level_q == {LW{1'b0}});
   assign level     = level_q;
   assign dout      = mem_q[rd_ptr_q];
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;

   // Next-state for pointers and occupancy; pointers wrap naturally at 2**AW
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         level_q  <= {LW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array; contents need no reset because the pointers define validity
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule : sync_fifo

// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
// Buffered 8N1 UART transmitter. Bytes from the command parser are queued in a
// small FIFO and serialized LSB first onto the TX pin, frames back-to-back.
// Ports:
//  clk          in   1          system clock
//  rstn         in   1          synchronous active-low reset (drops queued bytes)
//  tx_data      in   8          byte to send; taken when new_tx_data=1, tx_busy=0
//  new_tx_data  in   1          write strobe; may be held high
//  tx_busy      out  1          FIFO full; a write this cycle is refused
//  tx           out  1          registered serial line, idle high
//  fifo_level   out  FIFO_AW+1  queued bytes, not counting the one being shifted
//  overflow     out  1          one-cycle pulse after a refused write
// -----------------------------------------------------------------------------
module uart_tx_buffered
   import uart_tx_buffered_pkg::*;
#(
   parameter int unsigned BAUD_DIV = B115200,
   parameter int unsigned FIFO_AW  = 4
)(
   input  logic               clk,
   input  logic               rstn,
   input  logic [7:0]         tx_data,
   input  logic               new_tx_data,
   output logic               tx_busy,
   output logic               tx,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               overflow
);

   localparam int unsigned     CNT_W     = $clog2(BAUD_DIV);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } ser_state_e;

   ser_state_e       state_q,    state_d;
   logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]       bit_cnt_q,  bit_cnt_d;
   logic [7:0]       shift_q,    shift_d;
   logic             tx_q,       tx_d;
   logic             overflow_q, overflow_d;

   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic [7:0]       fifo_head_s;
   logic             pop_s;
   logic             bit_done_s;

   sync_fifo #(
      .W  (8),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (new_tx_data),
      .pop   (pop_s),
      .din   (tx_data),
      .dout  (fifo_head_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .level (fifo_level)
   );

   assign tx_busy    = fifo_full_s;
   assign tx         = tx_q;
   assign overflow   = overflow_q;
   assign bit_done_s = (baud_cnt_q == {CNT_W{1'b0}});
   // The FIFO already refuses writes when full, so a refused write is exactly
   // a strobe seen while busy.
   assign overflow_d = new_tx_data & fifo_full_s;

   // Serializer next-state. tx_d is derived from the current state, so the
   // pin lags the FSM by one clock: pop at E+1, start bit visible from E+2.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      pop_s      = 1'b0;
      tx_d       = 1'b1;
      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty_s) begin
               pop_s      = 1'b1;
               shift_d    = fifo_head_s;
               baud_cnt_d = BAUD_LAST;
               bit_cnt_d  = 3'd0;
               state_d    = ST_START;
            end else begin
               state_d    = ST_IDLE;
            end
         end
         ST_START: begin
            tx_d = 1'b0;
            if (bit_done_s) begin
               baud_cnt_d = BAUD_LAST;
               bit_cnt_d  = 3'd0;
               state_d    = ST_DATA;
            end else begin
               baud_cnt_d = baud_cnt_q - CNT_W'(1);
            end
         end
         ST_DATA: begin
            tx_d = shift_q[0];
            if (bit_done_s) begin
               baud_cnt_d = BAUD_LAST;
               shift_d    = {1'b0, shift_q[7:1]};
               if (bit_cnt_q == LAST_DATA_BIT) begin
                  state_d   = ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - CNT_W'(1);
            end
         end
         ST_STOP: begin
            tx_d = 1'b1;
            if (bit_done_s) begin
               baud_cnt_d = BAUD_LAST;
               // Chain straight into the next frame when data is waiting
               if (!fifo_empty_s) begin
                  pop_s     = 1'b1;
                  shift_d   = fifo_head_s;
                  bit_cnt_d = 3'd0;
                  state_d   = ST_START;
               end else begin
                  state_d   = ST_IDLE;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - CNT_W'(1);
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Serializer and output registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         baud_cnt_q <= {CNT_W{1'b0}};
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'd0;
         tx_q       <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         overflow_q <= overflow_d;
      end
   end

endmodule : uart_tx_buffered

// File: tb/tb_uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buffered
// Bench for uart_tx_buffered (BAUD_DIV=4, FIFO_AW=4). A queue-based model tracks
// what has been accepted, when the transmitter takes the next byte, and what
// the line should show at each clock; a line decoder rebuilds bytes from tx.
// -----------------------------------------------------------------------------
module tb_uart_tx_buffered;

   localparam int BAUD  = 4;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int FRAME = 10 * BAUD;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          new_tx_data = 1'b0;
   logic [7:0]    tx_data = 8'd0;
   logic          tx_busy;
   logic          tx;
   logic [AW:0]   fifo_level;
   logic          overflow;

   always #5 clk = ~clk;

   uart_tx_buffered #(
      .BAUD_DIV (BAUD),
      .FIFO_AW  (AW)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .tx_data     (tx_data),
      .new_tx_data (new_tx_data),
      .tx_busy     (tx_busy),
      .tx          (tx),
      .fifo_level  (fifo_level),
      .overflow    (overflow)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   logic [7:0] mq[$];      // bytes waiting in the FIFO
   logic [7:0] sent[$];    // bytes handed to the line, awaiting decode
   bit         in_frame = 1'b0;
   int         pos = 0;    // clocks since the current frame's byte was taken
   logic [7:0] cur = 8'd0;
   logic       exp_tx = 1'b1;
   logic       exp_ovf = 1'b0;
   int         drops = 0;
   int         ovf_seen = 0;
   int         accepted = 0;

   // line decoder state
   bit         dec_on = 1'b0;
   int         dec_idx = 0;
   logic [7:0] dec_byte = 8'd0;
   int         decoded = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic decode();
      logic [7:0] want;
      if (!dec_on) begin
         if (tx === 1'b0) begin
            dec_on  = 1'b1;
            dec_idx = 0;
         end
      end else begin
         dec_idx++;
         if ((dec_idx % BAUD) == BAUD / 2 && dec_idx / BAUD >= 1 && dec_idx / BAUD <= 8)
            dec_byte[dec_idx / BAUD - 1] = tx;
         if (dec_idx == 9 * BAUD + BAUD / 2) begin
            chk("stop_bit", tx, 1);
            chk("rx_pending", sent.size() > 0, 1);
            if (sent.size() > 0) begin
               want = sent.pop_front();
               chk("rx_byte", dec_byte, want);
               decoded++;
            end
         end
         if (dec_idx == FRAME - 1) dec_on = 1'b0;
      end
   endtask

   // one clock: drive, advance the model at the edge, check at the falling edge
   task automatic step(input logic r, input logic s, input logic [7:0] d);
      int b;
      bit pop, acc;
      rstn = r; new_tx_data = s; tx_data = d;
      @(posedge clk);
      if (!r) begin
         mq.delete(); sent.delete();
         in_frame = 1'b0; pos = 0; exp_tx = 1'b1; exp_ovf = 1'b0; dec_on = 1'b0;
      end else begin
         if (in_frame) begin
            b = pos / BAUD;
            if (b == 0)      exp_tx = 1'b0;
            else if (b <= 8) exp_tx = cur[b - 1];
            else             exp_tx = 1'b1;
         end else begin
            exp_tx = 1'b1;
         end
         pop     = (mq.size() > 0) && (!in_frame || pos == FRAME - 1);
         acc     = s && (mq.size() < DEPTH);
         exp_ovf = s && (mq.size() == DEPTH);
         if (exp_ovf) drops++;
         if (pop) begin cur = mq.pop_front(); sent.push_back(cur); end
         if (acc) begin mq.push_back(d); accepted++; end
         if (pop) begin
            in_frame = 1'b1; pos = 0;
         end else if (in_frame) begin
            pos++;
            if (pos == FRAME) in_frame = 1'b0;
         end
      end
      @(negedge clk);
      chk("tx", tx, exp_tx);
      chk("fifo_level", fifo_level, mq.size());
      chk("tx_busy", tx_busy, mq.size() == DEPTH);
      chk("overflow", overflow, exp_ovf);
      if (overflow === 1'b1) ovf_seen++;
      if (r) decode();
   endtask

   task automatic drain();
      int k = 0;
      while ((mq.size() != 0 || in_frame) && k < 3000) begin
         step(1'b1, 1'b0, 8'd0);
         k++;
      end
      chk("drain_done", (mq.size() == 0 && !in_frame), 1);
      repeat (3) step(1'b1, 1'b0, 8'd0);
   endtask

   initial begin
      int target, iter, len, gap;
      repeat (3) step(1'b0, 1'b0, 8'd0);

      // single byte, full frame
      step(1'b1, 1'b1, 8'h55);
      repeat (45) step(1'b1, 1'b0, 8'd0);

      // strobe held: 17 accepted, three refused within 20 clocks
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'($urandom));
      chk("burst_level", fifo_level, DEPTH);
      chk("burst_ovf", ovf_seen, 3);
      // keep holding so frame-end pops meet a full FIFO
      for (int i = 0; i < 90; i++) step(1'b1, 1'b1, 8'($urandom));
      drain();

      // two bytes on consecutive clocks, contiguous frames
      step(1'b1, 1'b1, 8'hA3);
      step(1'b1, 1'b1, 8'h0F);
      drain();

      // reset mid-frame during data bit 3 with bytes queued
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'($urandom));
      repeat (14) step(1'b1, 1'b0, 8'd0);
      step(1'b0, 1'b0, 8'd0);
      repeat (60) step(1'b1, 1'b0, 8'd0);

      // random bursts
      target = accepted + 1100;
      iter = 0;
      while (accepted < target && iter < 5000) begin
         len = $urandom_range(1, 24);
         for (int i = 0; i < len; i++)
            step(1'b1, ($urandom_range(0, 3) != 0), 8'($urandom));
         gap = $urandom_range(0, 100);
         for (int i = 0; i < gap; i++) step(1'b1, 1'b0, 8'd0);
         iter++;
      end
      drain();

      chk("drops_vs_ovf", ovf_seen, drops);
      chk("rx_all_decoded", sent.size(), 0);
      chk("decoded_nonzero", decoded > 1000, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_uart_tx_buffered
